// File: rtl/seg_scan_capture.sv
// seg_scan_capture: readback monitor for the multiplexed 7-segment display path.
// Resyncs the scan lines, captures settled digits and decodes complete frames.
module seg_scan_capture #(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Catodo,
  input  logic [3:0] Seleccion,
  output logic [3:0] unidades_bcd,
  output logic [3:0] decenas_bcd,
  output logic [6:0] temp_bin,
  output logic [1:0] estado_cod,
  output logic [6:0] actividad_seg,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       stale
);

  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYC);
  localparam logic [CW-1:0] CNT_CAP = CW'(SETTLE_CYC - 2);
  localparam logic [15:0] T_MAX = 16'(TIMEOUT_CYC);
  localparam logic [15:0] T_EXP = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    CHECK
  } state_t;

  state_t state;

  logic [10:0]   s1, s2, prv;
  logic [CW-1:0] cnt;
  logic [6:0]    slot [4];
  logic [3:0]    seen;
  logic [15:0]   tcnt;

  logic [3:0] sel;
  logic [3:0] oh;
  logic [1:0] idx;
  logic       same;
  logic       cap;
  logic       expire;
  logic [4:0] u_dec, t_dec;
  logic [2:0] s_dec;
  logic       ok;
  logic [6:0] temp;

  function automatic logic [4:0] dec_bcd(input logic [6:0] p);
    case (p)
      7'b0000001: dec_bcd = {1'b1, 4'd0};
      7'b1001111: dec_bcd = {1'b1, 4'd1};
      7'b0010010: dec_bcd = {1'b1, 4'd2};
      7'b0000110: dec_bcd = {1'b1, 4'd3};
      7'b1001100: dec_bcd = {1'b1, 4'd4};
      7'b0100100: dec_bcd = {1'b1, 4'd5};
      7'b0100000: dec_bcd = {1'b1, 4'd6};
      7'b0001111: dec_bcd = {1'b1, 4'd7};
      7'b0000000: dec_bcd = {1'b1, 4'd8};
      7'b0000100: dec_bcd = {1'b1, 4'd9};
      default:    dec_bcd = 5'd0;
    endcase
  endfunction

  function automatic logic [2:0] dec_state(input logic [6:0] p);
    case (p)
      7'b1001111: dec_state = {1'b1, 2'd1};
      7'b0010010: dec_state = {1'b1, 2'd2};
      7'b0000110: dec_state = {1'b1, 2'd3};
      default:    dec_state = 3'd0;
    endcase
  endfunction

  always_comb begin
    sel = s2[10:7];
    oh  = ~sel;
    idx = 2'd0;
    case (sel)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    same   = (s2 == prv);
    // one capture per dwell: the count saturates past the capture point
    cap    = same && (cnt == CNT_CAP) && $onehot(oh);
    expire = !cap && (tcnt == T_EXP);
    u_dec  = dec_bcd(slot[0]);
    t_dec  = dec_bcd(slot[1]);
    s_dec  = dec_state(slot[2]);
    ok     = u_dec[4] & t_dec[4] & s_dec[2];
    temp   = 7'(t_dec[3:0]) * 7'd10 + 7'(u_dec[3:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1            <= '1;
      s2            <= '1;
      prv           <= '1;
      cnt           <= '0;
      for (int i = 0; i < 4; i++) slot[i] <= '0;
      seen          <= '0;
      tcnt          <= '0;
      state         <= IDLE;
      unidades_bcd  <= '0;
      decenas_bcd   <= '0;
      temp_bin      <= '0;
      estado_cod    <= '0;
      actividad_seg <= '0;
      frame_valid   <= 1'b0;
      frame_err     <= 1'b0;
      stale         <= 1'b0;
    end else begin
      s1  <= {Seleccion, Catodo};
      s2  <= s1;
      prv <= s2;
      if (!same) cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;

      frame_valid <= 1'b0;
      frame_err   <= 1'b0;

      if (cap) begin
        slot[idx] <= s2[6:0];
        tcnt      <= '0;
      end else if (tcnt != T_MAX) begin
        tcnt <= tcnt + 16'd1;
      end

      case (state)
        IDLE: begin
          if (cap) begin
            seen  <= oh;
            state <= COLLECT;
          end
        end
        COLLECT: begin
          if (cap) seen <= seen | oh;
          if (seen == 4'hF) state <= CHECK;
        end
        CHECK: begin
          if (ok) begin
            unidades_bcd  <= u_dec[3:0];
            decenas_bcd   <= t_dec[3:0];
            temp_bin      <= temp;
            estado_cod    <= s_dec[1:0];
            actividad_seg <= slot[3];
            frame_valid   <= 1'b1;
            stale         <= 1'b0;
          end else begin
            frame_err <= 1'b1;
          end
          seen  <= cap ? oh : 4'h0;
          state <= COLLECT;
        end
        default: state <= IDLE;
      endcase

      if (expire) begin
        stale <= 1'b1;
        seen  <= '0;
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: directed scans of the display lines with
// hand-computed decoded values, pulse counts and stale timing.
module tb_seg_scan_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] cat;
  logic [3:0] sel;
  logic [3:0] unidades_bcd;
  logic [3:0] decenas_bcd;
  logic [6:0] temp_bin;
  logic [1:0] estado_cod;
  logic [6:0] actividad_seg;
  logic       frame_valid;
  logic       frame_err;
  logic       stale;

  int checks = 0;
  int errors = 0;
  int nfv    = 0;
  int nfe    = 0;
  int nboth  = 0;
  int exp_fv = 0;
  int exp_fe = 0;
  int stale_at;

  localparam logic [6:0] P1 = 7'b1001111;
  localparam logic [6:0] P2 = 7'b0010010;
  localparam logic [6:0] P3 = 7'b0000110;
  localparam logic [6:0] P5 = 7'b0100100;
  localparam logic [6:0] P7 = 7'b0001111;
  localparam logic [6:0] BL = 7'b1111111;

  seg_scan_capture #(
    .SETTLE_CYC (4),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .Catodo       (cat),
    .Seleccion    (sel),
    .unidades_bcd (unidades_bcd),
    .decenas_bcd  (decenas_bcd),
    .temp_bin     (temp_bin),
    .estado_cod   (estado_cod),
    .actividad_seg(actividad_seg),
    .frame_valid  (frame_valid),
    .frame_err    (frame_err),
    .stale        (stale)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) nfv++;
    if (frame_err) nfe++;
    if (frame_valid && frame_err) nboth++;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] se, input logic [6:0] c,
                       input int n);
    sel = se;
    cat = c;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [6:0] u, input logic [6:0] t,
                      input logic [6:0] s, input logic [6:0] a);
    drive(4'b1110, u, 16);
    drive(4'b1101, t, 16);
    drive(4'b1011, s, 16);
    drive(4'b0111, a, 16);
    drive(4'hF, BL, 4);
  endtask

  task automatic outs(input string tag, input int u, input int t,
                      input int tb, input int st, input int a);
    check({tag, "_units"}, unidades_bcd, u);
    check({tag, "_tens"}, decenas_bcd, t);
    check({tag, "_temp"}, temp_bin, tb);
    check({tag, "_state"}, estado_cod, st);
    check({tag, "_act"}, actividad_seg, a);
  endtask

  task automatic pulses(input string tag);
    check({tag, "_nvalid"}, nfv, exp_fv);
    check({tag, "_nerr"}, nfe, exp_fe);
  endtask

  initial begin
    rst = 1'b1;
    sel = 4'hF;
    cat = BL;
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    outs("reset", 0, 0, 0, 0, 0);
    check("reset_valid", frame_valid, 0);
    check("reset_err", frame_err, 0);
    check("reset_stale", stale, 0);

    // basic frame: 25 C, leer, activity 7E
    scan(P5, P2, P1, 7'h7E);
    exp_fv++;
    pulses("frame25");
    outs("frame25", 5, 2, 25, 1, 'h7E);
    scan(P5, P2, P1, 7'h7E);
    exp_fv++;
    pulses("frame25b");

    // units dwell too short: no frame this scan
    drive(4'b1110, P5, 3);
    drive(4'b1101, P2, 16);
    drive(4'b1011, P1, 16);
    drive(4'b0111, 7'h7E, 16);
    drive(4'hF, BL, 4);
    pulses("short");
    scan(P5, P2, P1, 7'h7E);
    exp_fv++;
    pulses("short_next");

    // two enables low: must not capture the missing units digit
    drive(4'b0011, P5, 20);
    pulses("twosel");

    // overwrite tens only, then let the timeout run out
    sel = 4'b1101;
    cat = P2;
    stale_at = -1;
    for (int i = 1; i <= 110; i++) begin
      @(negedge clk);
      if (stale && stale_at < 0) stale_at = i;
    end
    check("stale_cycle", stale_at, 106);
    check("stale_hold_temp", temp_bin, 25);
    drive(4'hF, BL, 4);
    pulses("stale");

    scan(P1, P3, P3, 7'h3F);
    exp_fv++;
    pulses("frame31");
    check("frame31_stale", stale, 0);
    outs("frame31", 1, 3, 31, 3, 'h3F);

    // bad tens digit after a good frame
    scan(P5, P2, P1, 7'h7E);
    exp_fv++;
    pulses("frame25c");
    scan(P7, BL, P2, 7'h00);
    exp_fe++;
    pulses("bad");
    outs("bad", 5, 2, 25, 1, 'h7E);

    // reset after two digits discards them
    drive(4'b1110, P5, 16);
    drive(4'b1101, P2, 16);
    drive(4'hF, BL, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    outs("midrst", 0, 0, 0, 0, 0);
    check("midrst_stale", stale, 0);
    drive(4'b1011, P1, 16);
    drive(4'b0111, 7'h7E, 16);
    drive(4'hF, BL, 4);
    pulses("midrst_part");
    scan(P5, P2, P1, 7'h7E);
    exp_fv++;
    pulses("midrst_full");
    outs("midrst_full", 5, 2, 25, 1, 'h7E);
    check("never_both", nboth, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
